sr_pulse_ctrl: RTL

- Upstream driver for the SR latch stage.
- Takes two raw, bouncy, asynchronous push-button levels (set and reset) and synchronises and debounces each one.
- Converts each debounced rising edge into a single-cycle S or R pulse, with a matching enable E.
- Guarantees S and R are never asserted together, so the downstream latch never sees the forbidden S=R=1 input.

---
 rtl/sr_ctrl_pkg.sv | 16 +
 rtl/debounce_chan.sv | 63 ++++++
 rtl/sr_pulse_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types and defaults for the SR latch pulse controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package sr_ctrl_pkg;

    localparam int DB_CYCLES_DEF = 4;
    localparam int CNT_W_DEF     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        RST_P = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchroniser, debounce counter, rising-edge request.
// Latency: req is high DB_CYCLES+2 edges after a stable input change (one cycle wide).
// Backpressure: none; req is a single-cycle strobe that the consumer must capture.
module debounce_chan
    import sr_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic req
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic             db;
    logic             db_d;
    logic [CNT_W-1:0] count;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync      <= sync_meta;
        end
    end

    // Debounce: the level must differ from db for DB_CYCLES consecutive edges to flip;
    // the count clears on flip, so it never reaches a value that could wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db    <= 1'b0;
            count <= '0;
        end else if (sync == db) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            db    <= sync;
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_d <= 1'b0;
        end else begin
            db_d <= db;
        end
    end

    // Rising edges only; releasing the button produces nothing.
    assign req = db & ~db_d;

endmodule

// File: rtl/sr_pulse_ctrl.sv
// Turns debounced set/reset button presses into exclusive one-cycle S/R pulses plus enable.
// Latency: pulse is high from edge DB_CYCLES+3 to DB_CYCLES+4 after a stable press.
// Backpressure: none upstream; requests arriving mid-pulse wait in one pending bit per type.
module sr_pulse_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic SET_BTN,
    input  logic RST_BTN,
    output logic S,
    output logic R,
    output logic E,
    output logic CONFLICT
);

    state_t state;
    state_t state_nxt;
    logic   set_req;
    logic   rst_req;
    logic   pend_s;
    logic   pend_r;
    logic   pend_s_nxt;
    logic   pend_r_nxt;
    logic   want_s;
    logic   want_r;
    logic   conflict_nxt;

    debounce_chan #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_set_chan (
        .clk   (CLK),
        .rst_n (RST_n),
        .btn   (SET_BTN),
        .req   (set_req)
    );

    debounce_chan #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_rst_chan (
        .clk   (CLK),
        .rst_n (RST_n),
        .btn   (RST_BTN),
        .req   (rst_req)
    );

    // State, pending requests and Moore outputs; outputs are decoded from the next state
    // so they change on the same edge as the state register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            E        <= 1'b0;
            CONFLICT <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_s   <= pend_s_nxt;
            pend_r   <= pend_r_nxt;
            S        <= (state_nxt == SET_P);
            R        <= (state_nxt == RST_P);
            E        <= (state_nxt == SET_P) || (state_nxt == RST_P);
            CONFLICT <= conflict_nxt;
        end
    end

    // Next-state: IDLE acts on live requests (plus anything that slipped in during the
    // last GAP), GAP acts on queued ones; a simultaneous set+reset is dropped and flagged.
    always_comb begin
        state_nxt    = state;
        want_s       = 1'b0;
        want_r       = 1'b0;
        conflict_nxt = 1'b0;

        if (state == IDLE) begin
            want_s = set_req | pend_s;
            want_r = rst_req | pend_r;
        end else if (state == GAP) begin
            want_s = pend_s;
            want_r = pend_r;
        end

        case (state)
            SET_P, RST_P: state_nxt = GAP;
            default: begin
                if (want_s && want_r) begin
                    state_nxt    = IDLE;
                    conflict_nxt = 1'b1;
                end else if (want_s) begin
                    state_nxt = SET_P;
                end else if (want_r) begin
                    state_nxt = RST_P;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase

        // A decision consumes the pending bit; a request arriving outside IDLE is queued
        // (a repeat while already pending merges into the same bit).
        pend_s_nxt = (pend_s & ~(state_nxt == SET_P) & ~conflict_nxt)
                   | (set_req & (state != IDLE));
        pend_r_nxt = (pend_r & ~(state_nxt == RST_P) & ~conflict_nxt)
                   | (rst_req & (state != IDLE));
    end

endmodule
